// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 key-schedule constants, Rcon table, S-box function, FSM encoding
package aes_pkg;

    localparam int AES_NUM_KEYS = 11;
    localparam int AES_KEY_W    = 128;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

    function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    aes_rcon = 8'h01;
            4'd1:    aes_rcon = 8'h02;
            4'd2:    aes_rcon = 8'h04;
            4'd3:    aes_rcon = 8'h08;
            4'd4:    aes_rcon = 8'h10;
            4'd5:    aes_rcon = 8'h20;
            4'd6:    aes_rcon = 8'h40;
            4'd7:    aes_rcon = 8'h80;
            4'd8:    aes_rcon = 8'h1b;
            4'd9:    aes_rcon = 8'h36;
            default: aes_rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box built algebraically: x^254 is the GF(2^8) inverse (0 maps to 0), then the affine map
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/key_round_step.sv
// rtl/key_round_step.sv - combinational AES-128 key-expansion round step with its S-box lanes
module s_box
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);
    assign dout = aes_sbox(din);
endmodule

module key_round_step
    import aes_pkg::*;
(
    input  logic [127:0] prev,
    input  logic [7:0]   rcon,
    output logic [127:0] next
);
    logic [31:0] rot;
    logic [31:0] sub;
    logic [31:0] c3;
    logic [31:0] c2;
    logic [31:0] c1;
    logic [31:0] c0;

    assign rot = {prev[23:0], prev[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        s_box u_s_box (
            .din  (rot[8*g +: 8]),
            .dout (sub[8*g +: 8])
        );
    end

    assign c3   = sub ^ prev[127:96] ^ {rcon, 24'h000000};
    assign c2   = c3 ^ prev[95:64];
    assign c1   = c2 ^ prev[63:32];
    assign c0   = c1 ^ prev[31:0];
    assign next = {c3, c2, c1, c0};
endmodule

// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - iterative AES-128 key schedule with indexed round-key read port
// Optional KEY_SCHED_DEC_EN adds rd_dec for reverse-order (decryption) key reads.
module key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_KEYS = AES_NUM_KEYS,
    parameter int IDX_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [127:0]         key_in,
    input  logic                 key_in_valid,
    output logic                 key_in_ready,
    output logic                 busy,
    output logic                 keys_ready,
    input  logic                 rd_en,
    input  logic [IDX_W-1:0]     rd_idx,
`ifdef KEY_SCHED_DEC_EN
    input  logic                 rd_dec,
`endif
    output logic [127:0]         rd_key,
    output logic                 rd_valid,
    output logic                 rd_err
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

    logic [1:0]           state;
    logic [IDX_W-1:0]     cnt;
    logic [AES_KEY_W-1:0] slots [NUM_KEYS];
    logic [127:0]         step_out;
    logic [IDX_W-1:0]     phys;
    logic                 rd_ok;
    logic                 accept;

    assign key_in_ready = (state != ST_EXPAND);
    assign busy         = (state == ST_EXPAND);
    assign keys_ready   = (state == ST_READY);
    assign accept       = key_in_valid && key_in_ready;

    key_round_step u_step (
        .prev (slots[cnt]),
        .rcon (aes_rcon(cnt)),
        .next (step_out)
    );

`ifdef KEY_SCHED_DEC_EN
    assign phys = rd_dec ? (LAST_IDX - rd_idx) : rd_idx;
`else
    assign phys = rd_idx;
`endif
    assign rd_ok = keys_ready && (rd_idx <= LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            for (int i = 0; i < NUM_KEYS; i++) slots[i] <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_READY: begin
                    if (accept) begin
                        slots[0] <= key_in;
                        cnt      <= '0;
                        state    <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    slots[cnt + 1'b1] <= step_out;
                    cnt               <= cnt + 1'b1;
                    if (cnt == LAST_IDX - 1'b1) state <= ST_READY;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Reads see pre-edge slot contents, so a read on a reload edge returns the old set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else if (rd_en) begin
            rd_valid <= 1'b1;
            rd_err   <= !rd_ok;
            rd_key   <= rd_ok ? slots[phys] : '0;
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - randomized bench with a word-level FIPS-197 key-expansion model
module tb_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_in_valid = 1'b0;
    logic         key_in_ready;
    logic         busy;
    logic         keys_ready;
    logic         rd_en = 1'b0;
    logic [3:0]   rd_idx = '0;
`ifdef KEY_SCHED_DEC_EN
    logic         rd_dec = 1'b0;
`endif
    logic [127:0] rd_key;
    logic         rd_valid;
    logic         rd_err;

    always #5 clk = ~clk;

    key_schedule_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .key_in       (key_in),
        .key_in_valid (key_in_valid),
        .key_in_ready (key_in_ready),
        .busy         (busy),
        .keys_ready   (keys_ready),
        .rd_en        (rd_en),
        .rd_idx       (rd_idx),
`ifdef KEY_SCHED_DEC_EN
        .rd_dec       (rd_dec),
`endif
        .rd_key       (rd_key),
        .rd_valid     (rd_valid),
        .rd_err       (rd_err)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic [2047:0] sbox_bits = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    logic [7:0] sbox_t [256];

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the committed key set, the set being built, and cycles left until it is usable
    logic [127:0] m_keys [11];
    logic [127:0] m_new  [11];
    int           m_rem   = 0;
    bit           m_ready = 1'b0;
    logic [127:0] e_key   = '0;
    logic         e_valid = 1'b0;
    logic         e_err   = 1'b0;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [127:0] model_key(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("key_in_ready", 128'(key_in_ready), 128'(m_rem == 0));
        chk("busy",         128'(busy),         128'(m_rem > 0));
        chk("keys_ready",   128'(keys_ready),   128'(m_ready));
        chk("rd_valid",     128'(rd_valid),     128'(e_valid));
        chk("rd_err",       128'(rd_err),       128'(e_err));
        chk("rd_key",       rd_key,             e_key);
    endtask

    // Inputs are already applied; predict this edge, take it, then compare
    task automatic cycle();
        bit acc;
        int phys;
        acc = key_in_valid && (m_rem == 0);
        if (rd_en) begin
            e_valid = 1'b1;
            phys = int'(rd_idx);
`ifdef KEY_SCHED_DEC_EN
            if (rd_dec) phys = 10 - int'(rd_idx);
`endif
            if (m_ready && rd_idx <= 4'd10) begin
                e_key = m_keys[phys];
                e_err = 1'b0;
            end else begin
                e_key = '0;
                e_err = 1'b1;
            end
        end else begin
            e_valid = 1'b0;
            e_err   = 1'b0;
        end
        if (acc) begin
            for (int r = 0; r < 11; r++) m_new[r] = model_key(key_in, r);
            m_rem   = 10;
            m_ready = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_ready = 1'b1;
                m_keys  = m_new;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        key_in_valid = 1'b0;
        rd_en        = 1'b0;
        m_rem   = 0;
        m_ready = 1'b0;
        e_key   = '0;
        e_valid = 1'b0;
        e_err   = 1'b0;
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic load(input logic [127:0] k);
        key_in       = k;
        key_in_valid = 1'b1;
        cycle();
        key_in_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!keys_ready && n < 20) begin
            cycle();
            n++;
        end
    endtask

    task automatic read(input logic [3:0] idx, input bit dec);
        rd_en  = 1'b1;
        rd_idx = idx;
`ifdef KEY_SCHED_DEC_EN
        rd_dec = dec;
`else
        if (dec) $display("note: reverse read requested without KEY_SCHED_DEC_EN");
`endif
        cycle();
        rd_en = 1'b0;
`ifdef KEY_SCHED_DEC_EN
        rd_dec = 1'b0;
`endif
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_bits[2047 - 8*i -: 8];
        for (int i = 0; i < 11; i++) begin
            m_keys[i] = '0;
            m_new[i]  = '0;
        end

        chk("model_fips_r1",  model_key(FIPS_KEY, 1),  FIPS_R1);
        chk("model_fips_r10", model_key(FIPS_KEY, 10), FIPS_R10);
        chk("model_zero_r1",  model_key('0, 1),        ZERO_R1);
        chk("model_zero_r10", model_key('0, 10),       ZERO_R10);

        do_reset();
        cycle();
        read(4'd0, 1'b0);
        chk("idle_read_err", 128'(rd_err), 128'd1);
        chk("idle_read_key", rd_key, '0);

        load(FIPS_KEY);
        wait_ready(n);
        chk("fips_latency", 128'(n), 128'd10);
        read(4'd1, 1'b0);
        chk("fips_idx1", rd_key, FIPS_R1);
        read(4'd10, 1'b0);
        chk("fips_idx10", rd_key, FIPS_R10);
        read(4'd11, 1'b0);
        chk("idx11_err", 128'(rd_err), 128'd1);
        read(4'd15, 1'b0);
        chk("idx15_key", rd_key, '0);
`ifdef KEY_SCHED_DEC_EN
        read(4'd0, 1'b1);
        chk("dec_idx0", rd_key, FIPS_R10);
        read(4'd11, 1'b1);
        chk("dec_idx11_err", 128'(rd_err), 128'd1);
`endif

        // Reload in READY with a read on the same edge: the read returns the old set
        key_in       = '0;
        key_in_valid = 1'b1;
        rd_en        = 1'b1;
        rd_idx       = 4'd10;
        cycle();
        key_in_valid = 1'b0;
        rd_en        = 1'b0;
        chk("read_on_reload_old", rd_key, FIPS_R10);
        key_in       = FIPS_KEY;
        key_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        key_in_valid = 1'b0;
        wait_ready(n);
        read(4'd1, 1'b0);
        chk("zero_idx1", rd_key, ZERO_R1);
        read(4'd10, 1'b0);
        chk("zero_idx10", rd_key, ZERO_R10);

        load(FIPS_KEY);
        for (int i = 0; i < 4; i++) cycle();
        do_reset();
        chk("reset_mid_ready", 128'(keys_ready), 128'd0);
        for (int i = 0; i < 12; i++) cycle();
        read(4'd0, 1'b0);
        chk("reset_mid_err", 128'(rd_err), 128'd1);
        load(FIPS_KEY);
        wait_ready(n);
        read(4'd10, 1'b0);
        chk("after_reset_idx10", rd_key, FIPS_R10);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                key_in       = {$urandom, $urandom, $urandom, $urandom};
                key_in_valid = ($urandom_range(0, 15) == 0);
                rd_en        = $urandom_range(0, 1) == 1;
                rd_idx       = 4'($urandom_range(0, 15));
`ifdef KEY_SCHED_DEC_EN
                rd_dec       = $urandom_range(0, 1) == 1;
`endif
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
